// File: rtl/matmul_controller.sv
// Sequencing FSM for the matrix-multiply datapath: loads A into mat1, B into mat2, then builds C in mat3.
// Latency: M*N + N*M accepted beats to load, then N+2 cycles per C element (M*M*(N+2) compute cycles).
// Backpressure: in_ready is high only in the load states; a beat is consumed on each in_valid cycle there.
module matmul_controller #(
    parameter int M      = 8,
    parameter int N      = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              m1EN,
    output logic              m1rEN,
    output logic              m1wEN,
    output logic              m2EN,
    output logic              m2rEN,
    output logic              m2wEN,
    output logic              m3EN,
    output logic              m3rEN,
    output logic              m3wEN,
    output logic              mult_ld,
    output logic              mult_rst,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic [ADDR_W-1:0] addr3,
    output logic [1:0]        shift_cnt,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int I_W   = (M > 1) ? $clog2(M) : 1;
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(M * N - 1);
    localparam logic [I_W-1:0]    I_LAST   = I_W'(M - 1);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(N - 1);
    localparam logic [ADDR_W-1:0] M_A      = ADDR_W'(M);
    localparam logic [ADDR_W-1:0] N_A      = ADDR_W'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [I_W-1:0]   i_q, i_d;
    logic [I_W-1:0]   j_q, j_d;
    logic [K_W-1:0]   k_q, k_d;

    assign shift_cnt = 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        in_ready = 1'b0;
        m1EN     = 1'b0;
        m1rEN    = 1'b0;
        m1wEN    = 1'b0;
        m2EN     = 1'b0;
        m2rEN    = 1'b0;
        m2wEN    = 1'b0;
        m3EN     = 1'b0;
        m3rEN    = 1'b0;
        m3wEN    = 1'b0;
        mult_ld  = 1'b0;
        mult_rst = 1'b0;
        addr1    = '0;
        addr2    = '0;
        addr3    = '0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    idx_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end

            // Write strobes and address only appear on accepted beats; bubbles leave mat1 idle.
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m1EN  = 1'b1;
                    m1wEN = 1'b1;
                    addr1 = ADDR_W'(idx_q);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m2EN  = 1'b1;
                    m2wEN = 1'b1;
                    addr2 = ADDR_W'(idx_q);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_MAC;
                        idx_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            // Read A[i][k] and B[k][j]; the product of the previous read is accumulated this cycle.
            S_MAC: begin
                m1EN     = 1'b1;
                m1rEN    = 1'b1;
                m2EN     = 1'b1;
                m2rEN    = 1'b1;
                addr1    = ADDR_W'(i_q) * N_A + ADDR_W'(k_q);
                addr2    = ADDR_W'(k_q) * M_A + ADDR_W'(j_q);
                mult_rst = (k_q == '0);
                mult_ld  = (k_q != '0);
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            S_DRAIN: begin
                mult_ld = 1'b1;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                m3EN  = 1'b1;
                m3wEN = 1'b1;
                addr3 = ADDR_W'(i_q) * M_A + ADDR_W'(j_q);
                if (j_q == I_LAST) begin
                    j_d = '0;
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + I_W'(1);
                        state_d = S_MAC;
                    end
                end else begin
                    j_d     = j_q + I_W'(1);
                    state_d = S_MAC;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
